// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequences 4:1 mux selects, samples z0 per channel, reports 4-bit scan words
// Ports: clk/rst (sync active-high); start requests a scan from IDLE; cont repeats scans;
// z0 is the scanned mux output; s1,s0 select the channel; busy is high in SCAN/DONE;
// done pulses for one cycle with data (bit n = channel n); scan_count counts completed scans.
module mux_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       z0,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] data,
  output logic [7:0] scan_count
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  localparam logic [7:0] LAST = 8'(DWELL - 1), SMP = 8'(SETTLE);
  // channel 3 is sampled on the same edge that latches data when the sample lands on the last dwell cycle
  localparam logic LATE = (SETTLE == DWELL - 1);
  logic [1:0] state, ch;
  logic [7:0] dwell;
  logic [3:0] shadow;
  assign s0   = ch[0];
  assign s1   = ch[1];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= 2'd0;
      dwell      <= 8'd0;
      shadow     <= 4'd0;
      data       <= 4'd0;
      scan_count <= 8'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= SCAN;
          ch     <= 2'd0;
          dwell  <= 8'd0;
          shadow <= 4'd0;
        end
        SCAN: begin
          if (dwell == SMP) shadow[ch] <= z0;
          if (dwell == LAST) begin
            dwell <= 8'd0;
            ch    <= ch + 2'd1;
            if (ch == 2'd3) begin
              state      <= DONE;
              data       <= {LATE ? z0 : shadow[3], shadow[2:0]};
              scan_count <= scan_count + 8'd1;
            end
          end else begin
            dwell <= dwell + 8'd1;
          end
        end
        DONE: begin
          state  <= cont ? SCAN : IDLE;
          ch     <= 2'd0;
          dwell  <= 8'd0;
          shadow <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 4:1 multiplexer: it drives the mux select lines `s0`/`s1` through channels 0→1→2→3, holds each channel for a programmable dwell time, and samples the mux output `z0` after a settle delay. At the end of each scan it presents the four sampled bits as one 4-bit word with a done pulse. It runs either single-shot or continuously, and counts completed scans.

## Interface
Parameters:
- `DWELL`, default 4: cycles the select lines hold each channel; legal range 1..255.
- `SETTLE`, default 1: cycle offset within a dwell at which `z0` is sampled; legal range 0..DWELL-1.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request a scan; honoured only in IDLE.
- `cont`  in  1  — continuous mode; sampled in DONE.
- `z0`  in  1  — mux output being scanned.
- `s0`  out  1  — mux select LSB, equal to `ch[0]`.
- `s1`  out  1  — mux select MSB, equal to `ch[1]`.
- `busy`  out  1  — high in SCAN and DONE.
- `done`  out  1  — one-cycle pulse, high in DONE.
- `data`  out  4  — last completed scan; bit n is channel n.
- `scan_count`  out  8  — completed scans, wraps 255→0.

## Operation
- Registers: state (IDLE, SCAN, DONE); `ch` 2-bit; `dwell` 8-bit; `shadow` 4-bit; `data` 4-bit; `scan_count` 8-bit.
- IDLE: `ch`=0 and `dwell`=0, so `s1`,`s0`=00. If `start`=1, go to SCAN with `ch`=0, `dwell`=0, `shadow`=0.
- SCAN, every cycle:
  - If `dwell`==SETTLE, write `shadow[ch]` ← `z0` at the clock edge.
  - If `dwell`==DWELL-1 and `ch`<3: `ch`++, `dwell`←0.
  - If `dwell`==DWELL-1 and `ch`==3: go to DONE. On that edge `data` ← `shadow` with bit 3 taken from this cycle's sample if SETTLE==DWELL-1. `scan_count`++ and `ch`←0.
  - Otherwise `dwell`++.
- DONE, exactly one cycle, `done`=1:
  - If `cont`=1, go to SCAN with `ch`=0, `dwell`=0, `shadow`=0.
  - Else go to IDLE.
- `start` is ignored outside IDLE, with no queuing.
- Deasserting `cont` mid-scan does not abort; the current scan completes, then the block goes to IDLE.
- `data` and `scan_count` hold their values between scans and in IDLE.
- Reset, at any time including mid-scan:
  - state=IDLE; `ch`, `dwell`, `shadow`, `data`, `scan_count` all 0.
  - Outputs: `s0`=0, `s1`=0, `busy`=0, `done`=0, `data`=0, `scan_count`=0.
  - A partial scan is discarded and `scan_count` does not increment.
- `rst` has priority over `start`.

## Timing
- All outputs are registered or decoded from state only. `z0` feeds only the `shadow` register; there is no combinational path from `z0` to any output.
- `start` high at edge E0 (in IDLE): SCAN begins at E0. Channel n is selected from edge E0+n·DWELL for DWELL cycles.
- Channel n is sampled at edge E0+n·DWELL+SETTLE+1, which gives the mux SETTLE full cycles after the select change.
- DONE is entered at edge E0+4·DWELL. `done` and the new `data` are visible in the same cycle. Return to IDLE, or restart, at E0+4·DWELL+1.
- Continuous-mode period: 4·DWELL+1 cycles per scan.
- DWELL=1, SETTLE=0: every cycle advances the channel; a scan takes 4 cycles plus 1 DONE cycle.

## Test plan
- Reset values: hold `rst` 3 cycles with `start`=1 → `s1`,`s0`=00; `busy`=0; `done`=0; `data`=0; `scan_count`=0.
- Single scan: DWELL=4, SETTLE=1, mux inputs d0..d3=1,0,1,1, `start` pulse at E0 → select sequence 00,01,10,11 with 4 cycles each; `done` high exactly in the cycle after E0+16; `data`=4'b1101; `scan_count`=1; `busy`=0 from E0+17.
- Settle check: change d2 from 0 to 1 exactly at the select change to channel 2, SETTLE=1 → `data[2]`=1. A glitch injected on `z0` only in dwell cycle 0 is not captured.
- Continuous mode: `cont`=1, 3 scans, then drop `cont` mid-scan 3 → `done` pulses 17 cycles apart; scan 3 completes; IDLE afterwards; `scan_count`=3.
- Mid-scan reset: assert `rst` during channel 2 → next cycle IDLE; `data`=0; `scan_count`=0; a new `start` produces a full clean scan.
- Edge cases:
  - DWELL=1, SETTLE=0 → `done` every 5 cycles in continuous mode.
  - `start` held high during SCAN causes no restart.
  - 256 continuous scans → `scan_count` wraps to 0.
